// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses the synchronous instruction ROM from next-PC
// and registers {pc, instruction} into the IF/ID pipeline register.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ROM_AW   = 8,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [31:0]       new_pc,
  input  logic              branch_flag,
  input  logic [31:0]       branch_target,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic [31:0]       id_pc,
  output logic [31:0]       id_inst,
  output logic              id_valid,
  output logic              id_adel
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] id_pc_q, id_inst_q;
  logic        id_valid_q, id_adel_q;
  logic        misaligned;

  // next_pc drives the ROM so its registered read lines up with pc on the following cycle.
  always_comb begin
    if (rst) begin
      pc_d = RESET_PC;
    end else if (flush) begin
      pc_d = new_pc;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (branch_flag) begin
      pc_d = branch_target;
    end else begin
      pc_d = pc_q + 32'd4;
    end
  end

  assign rom_addr   = pc_d[ROM_AW+1:2];
  assign misaligned = (pc_q[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      id_pc_q    <= 32'h0000_0000;
      id_inst_q  <= NOP_INST;
      id_valid_q <= 1'b0;
      id_adel_q  <= 1'b0;
    end else if (!stall) begin
      id_pc_q    <= pc_q;
      id_inst_q  <= misaligned ? NOP_INST : rom_data;
      id_valid_q <= 1'b1;
      id_adel_q  <= misaligned;
    end
  end

  assign id_pc    = id_pc_q;
  assign id_inst  = id_inst_q;
  assign id_valid = id_valid_q;
  assign id_adel  = id_adel_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a behavioural synchronous ROM plus hand-computed IF/ID expectations.
module tb_if_stage;

  localparam int unsigned ROM_AW = 8;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              rst, stall, flush, branch_flag;
  logic [31:0]       new_pc, branch_target;
  logic [ROM_AW-1:0] rom_addr;
  logic [31:0]       rom_data;
  logic [31:0]       id_pc, id_inst;
  logic              id_valid, id_adel;

  logic [31:0] mem [2**ROM_AW];
  int n_tests = 0;
  int n_fail  = 0;

  if_stage #(
    .RESET_PC(32'h0000_0000),
    .ROM_AW  (ROM_AW),
    .NOP_INST(NOP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .branch_flag  (branch_flag),
    .branch_target(branch_target),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .id_pc        (id_pc),
    .id_inst      (id_inst),
    .id_valid     (id_valid),
    .id_adel      (id_adel)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= mem[rom_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check_id(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                          input logic valid, input logic adel);
    check({tag, ".pc"},    id_pc,           pc);
    check({tag, ".inst"},  id_inst,         inst);
    check({tag, ".valid"}, {31'b0, id_valid}, {31'b0, valid});
    check({tag, ".adel"},  {31'b0, id_adel},  {31'b0, adel});
  endtask

  // Advance one edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; stall = 1'b0; flush = 1'b0; branch_flag = 1'b0;
    new_pc = 32'h0; branch_target = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2**ROM_AW; i++) mem[i] = 32'h1000_0000 + i;
    mem[0]  = 32'h0060_8640;
    mem[1]  = 32'h0068_8040;
    mem[2]  = 32'h0001_0134;
    mem[3]  = 32'h0000_01ac;
    mem[8]  = 32'h0080_033c;
    mem[64] = 32'h0068_0540;

    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    check_id("reset", 32'h0, NOP, 1'b0, 1'b0);
    check("reset.rom_addr", {24'b0, rom_addr}, 32'h0);
    rst = 1'b0;

    // 1: sequential fetch
    tick(); check_id("seq0", 32'h0, 32'h0060_8640, 1'b1, 1'b0);
    tick(); check_id("seq4", 32'h4, 32'h0068_8040, 1'b1, 1'b0);
    tick(); check_id("seq8", 32'h8, 32'h0001_0134, 1'b1, 1'b0);
    tick(); check_id("seqC", 32'hC, 32'h0000_01ac, 1'b1, 1'b0);

    // 2: branch with delay slot
    tick(); check_id("seq10", 32'h10, mem[4], 1'b1, 1'b0);
    branch_flag = 1'b1; branch_target = 32'h100;
    tick(); check_id("delay_slot", 32'h14, mem[5], 1'b1, 1'b0);
    idle_inputs();
    tick(); check_id("br_target", 32'h100, 32'h0068_0540, 1'b1, 1'b0);

    // 3: stall for 3 cycles at pc=0x8, with an ignored branch during the stall
    do_reset();
    tick();
    tick(); check_id("pre_stall", 32'h4, 32'h0068_8040, 1'b1, 1'b0);
    stall = 1'b1; branch_flag = 1'b1; branch_target = 32'h200;
    for (int i = 0; i < 3; i++) begin
      tick(); check_id($sformatf("stall%0d", i), 32'h4, 32'h0068_8040, 1'b1, 1'b0);
    end
    idle_inputs();
    tick(); check_id("resume8", 32'h8, 32'h0001_0134, 1'b1, 1'b0);
    tick(); check_id("resumeC", 32'hC, 32'h0000_01ac, 1'b1, 1'b0);

    // 4: flush overrides stall and branch
    flush = 1'b1; new_pc = 32'h20; stall = 1'b1; branch_flag = 1'b1; branch_target = 32'h300;
    tick(); check_id("flush", 32'h0, NOP, 1'b0, 1'b0);
    idle_inputs();
    tick(); check_id("flush_tgt", 32'h20, 32'h0080_033c, 1'b1, 1'b0);

    // 5: misaligned branch target
    branch_flag = 1'b1; branch_target = 32'h102;
    tick(); check_id("mis_slot", 32'h24, mem[9], 1'b1, 1'b0);
    idle_inputs();
    tick(); check_id("mis102", 32'h102, NOP, 1'b1, 1'b1);
    tick(); check_id("mis106", 32'h106, NOP, 1'b1, 1'b1);

    // PC wraps from 0xFFFF_FFFC to 0
    flush = 1'b1; new_pc = 32'hFFFF_FFFC;
    tick();
    idle_inputs();
    tick(); check_id("wrap_top", 32'hFFFF_FFFC, mem[255], 1'b1, 1'b0);
    tick(); check_id("wrap_zero", 32'h0, 32'h0060_8640, 1'b1, 1'b0);

    // 6: reset mid-stream at pc=0x40, with a branch that must not survive
    flush = 1'b1; new_pc = 32'h3C;
    tick();
    idle_inputs();
    tick(); check_id("pre_rst", 32'h3C, mem[15], 1'b1, 1'b0);
    rst = 1'b1; branch_flag = 1'b1; branch_target = 32'h200;
    tick(); check_id("mid_rst", 32'h0, NOP, 1'b0, 1'b0);
    idle_inputs();
    tick(); check_id("restart0", 32'h0, 32'h0060_8640, 1'b1, 1'b0);
    tick(); check_id("restart4", 32'h4, 32'h0068_8040, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
